serial_adder: RTL



---
 rtl/serial_adder.sv | 111 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Multi-cycle adder: WIDTH-bit a+b+cin, DIGIT bits per clock through one registered carry.
// Result valid WIDTH/DIGIT edges after acceptance, held until out_ready; no operand accepted while busy or holding.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);
   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [DIGIT:0]   dsum;
   logic             msb_cin;
   logic [WIDTH-1:0] acc_next;

   assign dsum     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
   // Carry into the digit's top bit recovered from its sum and operand bits.
   assign msb_cin  = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
   assign acc_next = (acc_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            carry_d = dsum[DIGIT];
            acc_d   = acc_next;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(STEPS - 1)) begin
               sum_d   = acc_next;
               cout_d  = dsum[DIGIT];
               ovf_d   = msb_cin ^ dsum[DIGIT];
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == HOLD);
   assign busy      = (state_q == RUN);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
endmodule
